// File: rtl/sram_like_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sram_like_pkg                                              |
// | Brief   : shared types and constants for the like-SRAM responder     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sram_like_pkg;

   localparam logic [1:0]  SIZE_BYTE = 2'd0;
   localparam logic [1:0]  SIZE_HALF = 2'd1;
   localparam logic [1:0]  SIZE_WORD = 2'd2;

   // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic        wr;
      logic [31:0] data;
   } resp_entry_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : resp_fifo                                                  |
// | Brief   : synchronous FIFO of response entries, head is show-ahead   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module resp_fifo
   import sram_like_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic                     pop,
   input  resp_entry_t              din,
   output resp_entry_t              head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   resp_entry_t   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   // Pointers are exactly log2(DEPTH) wide so they wrap on their own
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         if (push && !pop)      r_count <= r_count + CW'(1);
         else if (!push && pop) r_count <= r_count - CW'(1);
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sram_like_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sram_like_responder                                        |
// | Brief   : like-SRAM slave with word memory, latency and back-pressure|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sram_like_responder
   import sram_like_pkg::*;
#(
   parameter int          DEPTH_LOG2      = 10,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          LATENCY         = 1,
   parameter bit          RAND_EN         = 1'b0,
   parameter logic [15:0] SEED            = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] c_max_out  = CW'(MAX_OUTSTANDING);
   localparam logic [TW-1:0] c_lat_last = TW'(LATENCY - 1);

   logic [31:0]           r_mem [2**DEPTH_LOG2];
   logic [15:0]           r_lfsr;
   logic [TW-1:0]         r_cnt;
   logic [CW-1:0]         w_count;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_accept;
   logic                  w_gate_req;
   logic                  w_gate_rsp;
   resp_entry_t           w_push_entry;
   resp_entry_t           w_head;
   logic                  w_unused;

   assign w_idx      = addr[DEPTH_LOG2+1:2];
   assign w_gate_req = RAND_EN ? r_lfsr[0] : 1'b1;
   assign w_gate_rsp = RAND_EN ? r_lfsr[1] : 1'b1;

   // addr_ok never looks at req or at a pop in the same cycle
   assign addr_ok  = resetn & (w_count < c_max_out) & w_gate_req;
   assign w_accept = req & addr_ok;
   assign data_ok  = (w_count != '0) & (r_cnt == c_lat_last) & w_gate_rsp;
   assign rdata    = data_ok ? w_head.data : 32'd0;

   // Read data is captured at accept, so it reflects only earlier writes
   assign w_push_entry = '{wr: wr, data: (wr ? 32'd0 : r_mem[w_idx])};

   always_ff @(posedge clk) begin
      if (w_accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lfsr <= SEED;
         r_cnt  <= '0;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
         if (data_ok || (w_count == '0)) r_cnt <= '0;
         else if (r_cnt != c_lat_last)   r_cnt <= r_cnt + TW'(1);
      end
   end

   resp_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_resp_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (w_accept),
      .pop    (data_ok),
      .din    (w_push_entry),
      .head   (w_head),
      .count  (w_count)
   );

   assign w_unused = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0], w_head.wr};

endmodule
`default_nettype wire
